ps2_rx_fifo: RTL and testbench

- Keyboard front end between the PS/2 pins and the CPU's key I/O port.
- Synchronises and deglitches PS2_CLK/PS2_DAT into the system clock domain, then deserialises 11-bit PS/2 device-to-host frames.
- Stores validated scancode bytes in a small FIFO.
- Presents a show-ahead read port plus a level interrupt request for the datapath's irq logic.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_byte_fifo.sv | 96 +++++++++
 rtl/ps2_rx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam logic        PS2_START_BIT = 1'b0;
    localparam logic        PS2_STOP_BIT  = 1'b1;
    localparam int unsigned PS2_DATA_BITS = 8;
    localparam int unsigned PS2_ERR_W     = 8;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead synchronous byte FIFO: head always presents the oldest entry,
// and holds the last popped value once the FIFO drains.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             pop_ok_c, wr_en_c;

    // Pointer, level and show-ahead head update; a full FIFO still accepts
    // a push when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok_c = pop & ~empty_q;
        wr_en_c  = push & (~full_q | pop_ok_c);
        drop_c   = push & full_q & ~pop_ok_c;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en_c, pop_ok_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (pop_ok_c) begin
            if (level_q > LVL_W'(1)) begin
                head_d = mem_q[rd_ptr_d];
            end else if (wr_en_c) begin
                head_d = push_data;
            end
        end else if (wr_en_c && empty_q) begin
            head_d = push_data;
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign level = level_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin conditioning, frame deserialiser with timeout,
// scancode FIFO and sticky overflow flag.
import ps2_pkg::*;

module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ps2_clk,
    input  logic                         ps2_dat,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    output logic                         irq,
    output logic                         overflow,
    input  logic                         clr_overflow,
    output logic [PS2_ERR_W-1:0]         frame_err_count,
    output logic [$clog2(FIFO_DEPTH):0]  fill_level
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);

    logic [1:0]               sync_clk_q, sync_clk_d;
    logic [1:0]               sync_dat_q, sync_dat_d;
    logic                     filt_clk_q, filt_clk_d;
    logic [FLT_W-1:0]         filt_cnt_q, filt_cnt_d;
    logic                     fall_q, fall_d;

    ps2_rx_state_t            state_q, state_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                     parity_ok_q, parity_ok_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [PS2_ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic                     overflow_q, overflow_d;
    logic                     push_c, err_c, dat_c;

    logic                     fifo_empty, fifo_full, fifo_drop_c;

    // Pin synchronisers, PS/2 clock glitch filter and falling-edge strobe.
    always_comb begin
        sync_clk_d = {sync_clk_q[0], ps2_clk};
        sync_dat_d = {sync_dat_q[0], ps2_dat};
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (sync_clk_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = sync_clk_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FLT_W'(1);
            end
        end
        fall_d = filt_clk_q & ~filt_clk_d;
    end

    // Frame FSM next state, timeout and error accounting.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        parity_ok_d = parity_ok_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_cnt_d   = err_cnt_q;
        push_c      = 1'b0;
        err_c       = 1'b0;
        dat_c       = sync_dat_q[1];

        if (state_q == IDLE || fall_q) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall_q && dat_c == PS2_START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall_q) begin
                    shreg_d   = {dat_c, shreg_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_q) begin
                    parity_ok_d = ^{shreg_q, dat_c};
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    if (dat_c == PS2_STOP_BIT && parity_ok_q) begin
                        push_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A device that stops clocking mid-frame abandons the frame.
        if (state_q != IDLE && !fall_q && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            tmo_cnt_d = '0;
            err_c     = 1'b1;
        end

        if (err_c && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + PS2_ERR_W'(1);
        end

        // Dropping a byte sets the flag even when a clear arrives together.
        overflow_d = fifo_drop_c | (overflow_q & ~clr_overflow);
    end

    // State registers; synchronisers and filtered clock idle high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_clk_q  <= 2'b11;
            sync_dat_q  <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            parity_ok_q <= 1'b0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync_clk_q  <= sync_clk_d;
            sync_dat_q  <= sync_dat_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            parity_ok_q <= parity_ok_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .push      (push_c),
        .push_data (shreg_q),
        .pop       (rd_en),
        .head      (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fill_level),
        .drop_c    (fifo_drop_c)
    );

    // A byte can only be dropped while the FIFO reports full.
    drop_only_when_full: assert property (@(posedge clock) disable iff (!reset)
        fifo_drop_c |-> fifo_full);

    assign rd_valid        = ~fifo_empty;
    assign irq             = rd_valid;
    assign overflow        = overflow_q;
    assign frame_err_count = err_cnt_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: PS/2 frame driver, queue-based reference model and
// a read monitor that pops and compares scancodes as the DUT presents them.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned FLT   = 8;
    localparam int unsigned TMO   = 2000;
    localparam int unsigned HALF  = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       irq;
    logic       overflow;
    logic [7:0] frame_err_count;
    logic [4:0] fill_level;

    int checks = 0;
    int failures = 0;

    byte unsigned exp_q[$];
    byte unsigned mon_exp;
    int           err_model = 0;
    bit           ovf_model = 1'b0;
    bit           reading = 1'b0;

    always #5 clock = ~clock;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_clk         (ps2_clk),
        .ps2_dat         (ps2_dat),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .irq             (irq),
        .overflow        (overflow),
        .clr_overflow    (clr_overflow),
        .frame_err_count (frame_err_count),
        .fill_level      (fill_level)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what the receiver should conclude from a complete frame.
    task automatic model_frame(input byte unsigned d, input bit bad_par, input bit bad_stop);
        if (!bad_par && !bad_stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else ovf_model = 1'b1;
        end else if (err_model < 255) begin
            err_model++;
        end
    endtask

    // Drive the first nbits of a device-to-host frame onto the pins.
    task automatic send_frame(input byte unsigned d, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        bits[9]   = bad_par ? ^d : ~^d;
        bits[10]  = bad_stop ? 1'b0 : 1'b1;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) model_frame(d, bad_par, bad_stop);
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic check_status(input string tag, input bit with_level);
        check({tag, "_err_count"}, int'(frame_err_count), err_model);
        check({tag, "_overflow"}, int'(overflow), int'(ovf_model));
        if (with_level) begin
            check({tag, "_fill_level"}, int'(fill_level), exp_q.size());
            check({tag, "_rd_valid"}, int'(rd_valid), int'(exp_q.size() != 0));
            check({tag, "_irq"}, int'(irq), int'(exp_q.size() != 0));
        end
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        reading = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clock);
            if (!rd_valid) done = 1'b1;
        end
        reading = 1'b0;
        @(negedge clock);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout: rd_valid still 1 expected 0", tag);
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
        check({tag, "_drain_irq"}, int'(irq), 0);
    endtask

    // Monitor: randomly pops while reading is enabled and compares the head.
    initial begin
        forever begin
            @(negedge clock);
            rd_en = 1'b0;
            if (reading && rd_valid && $urandom_range(1, 0) == 1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got 0x%0h expected no data", rd_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rd_data", int'(rd_data), int'(mon_exp));
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_irq", int'(irq), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_err", int'(frame_err_count), 0);
        check("rst_fill", int'(fill_level), 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // 1: valid frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check_status("t1", 1'b1);
        check("t1_head", int'(rd_data), 8'h1C);
        drain("t1");

        // 2: parity error then good 0xF0
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        check_status("t2a", 1'b1);
        check("t2_err_one", int'(frame_err_count), 1);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        check_status("t2b", 1'b1);
        check("t2_head", int'(rd_data), 8'hF0);
        drain("t2");

        // 3: overflow with 17 frames, drain in order, clear flag
        for (int i = 0; i < 17; i++) send_frame(byte'(i), 1'b0, 1'b0, 11);
        check_status("t3", 1'b1);
        check("t3_full_level", int'(fill_level), 16);
        check("t3_ovf_set", int'(overflow), 1);
        drain("t3");
        @(negedge clock);
        clr_overflow = 1'b1;
        @(negedge clock);
        clr_overflow = 1'b0;
        ovf_model = 1'b0;
        @(negedge clock);
        check("t3_ovf_clr", int'(overflow), 0);

        // 4: timeout after start + 4 data bits, then 0x5A
        send_frame(8'h5A, 1'b0, 1'b0, 5);
        repeat (TMO + 10) @(negedge clock);
        err_model++;
        check_status("t4a", 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 11);
        check_status("t4b", 1'b1);
        check("t4_head", int'(rd_data), 8'h5A);
        drain("t4");

        // 5: short glitch on ps2_clk while idle
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clock);
        check_status("t5", 1'b1);
        send_frame(8'h3B, 1'b0, 1'b0, 11);
        check("t5_head", int'(rd_data), 8'h3B);
        drain("t5");

        // Random frames with concurrent random reads
        reading = 1'b1;
        for (int n = 0; n < 25; n++) begin
            send_frame(byte'($urandom_range(255, 0)), $urandom_range(7, 0) == 0,
                       $urandom_range(7, 0) == 0, 11);
            check_status("rnd", 1'b0);
        end
        drain("rnd");

        // 6: reset mid-frame, then 0x29
        send_frame(8'h77, 1'b0, 1'b0, 5);
        reset = 1'b0;
        exp_q.delete();
        err_model = 0;
        ovf_model = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_rst_err", int'(frame_err_count), 0);
        check("t6_rst_valid", int'(rd_valid), 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        send_frame(8'h29, 1'b0, 1'b0, 11);
        check_status("t6", 1'b1);
        check("t6_head", int'(rd_data), 8'h29);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
